// File: rtl/tuner_pkg.sv
// Constants, state encoding and sideband types shared by the tuner datapath blocks.
// No logic; imported by the FFT peak detector, FIFO read controller and note mapper.
package tuner_pkg;

  localparam int FFT_POINTS = 8192;
  localparam int BIN_W      = 13;
  localparam int MAG_IN_W   = 16;
  localparam int MAG_W      = 2 * MAG_IN_W + 1;

  localparam logic [MAG_W-1:0] THRESH_DEFAULT = 33'd1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             in_range;
  } bin_meta_t;

  function automatic logic bin_in_range(input logic [BIN_W-1:0] bin, input int lo, input int hi);
    int b;
    b = int'(bin);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/fft_peak_detector_if.sv
// FFT source stream (valid/ready with sop/eop framing and error code).
// master = FFT core side, slave = consumer; the consumer drives source_ready.
interface fft_peak_detector_if #(
  parameter int DATA_W = 32
);

  logic              source_valid;
  logic              source_sop;
  logic              source_eop;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic [1:0]        source_error;
  logic              source_ready;

  modport master (
    output source_valid, source_sop, source_eop, source_real, source_imag, source_error,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_real, source_imag, source_error,
    output source_ready
  );

endinterface

// File: rtl/fft_mag_sq.sv
// Two-stage truncate/square/sum pipeline with valid, bin and in-range sidebands.
// Latency 2 cycles from i_vld to o_vld; no backpressure, i_flush kills the beat moving S1->S2.
module fft_mag_sq
  import tuner_pkg::*;
#(
  parameter int MIN_BIN = 2,
  parameter int MAX_BIN = 4095
) (
  input  logic                       CLOCK_50,
  input  logic                       i_rst,
  input  logic                       i_vld,
  input  logic                       i_flush,
  input  logic signed [MAG_IN_W-1:0] i_re,
  input  logic signed [MAG_IN_W-1:0] i_im,
  input  logic [BIN_W-1:0]           i_bin,
  output logic                       o_s1_vld,
  output logic                       o_vld,
  output logic [MAG_W-1:0]           o_mag,
  output bin_meta_t                  o_meta
);

  logic                       r_s1_vld;
  logic signed [MAG_IN_W-1:0] r_s1_re;
  logic signed [MAG_IN_W-1:0] r_s1_im;
  bin_meta_t                  r_s1_meta;

  logic                       r_s2_vld;
  logic [MAG_W-1:0]           r_s2_mag;
  bin_meta_t                  r_s2_meta;

  logic signed [2*MAG_IN_W-1:0] w_re_ext;
  logic signed [2*MAG_IN_W-1:0] w_im_ext;
  logic signed [2*MAG_IN_W-1:0] w_re_sq;
  logic signed [2*MAG_IN_W-1:0] w_im_sq;
  logic [MAG_W-1:0]             w_mag;

  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_re   <= '0;
      r_s1_im   <= '0;
      r_s1_meta <= '0;
    end else begin
      r_s1_vld <= i_vld;
      if (i_vld) begin
        r_s1_re            <= i_re;
        r_s1_im            <= i_im;
        r_s1_meta.bin      <= i_bin;
        r_s1_meta.in_range <= bin_in_range(i_bin, MIN_BIN, MAX_BIN);
      end
    end
  end

  // Squares of a 16-bit signed value never exceed 2^30, so each fits a 32-bit signed result.
  assign w_re_ext = {{MAG_IN_W{r_s1_re[MAG_IN_W-1]}}, r_s1_re};
  assign w_im_ext = {{MAG_IN_W{r_s1_im[MAG_IN_W-1]}}, r_s1_im};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_mag    = {1'b0, w_re_sq} + {1'b0, w_im_sq};

  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_mag  <= '0;
      r_s2_meta <= '0;
    end else begin
      r_s2_vld <= r_s1_vld & ~i_flush;
      if (r_s1_vld) begin
        r_s2_mag  <= w_mag;
        r_s2_meta <= r_s1_meta;
      end
    end
  end

  assign o_s1_vld = r_s1_vld;
  assign o_vld    = r_s2_vld;
  assign o_mag    = r_s2_mag;
  assign o_meta   = r_s2_meta;

endmodule

// File: rtl/fft_peak_detector.sv
// Frames the FFT stream, tracks the max-magnitude bin in MIN_BIN..MAX_BIN, reports at eop edge + 3.
// Never backpressures (source_ready high out of reset); malformed frames give a frame_error pulse.
module fft_peak_detector
  import tuner_pkg::*;
#(
  parameter int               FFT_POINTS = tuner_pkg::FFT_POINTS,
  parameter int               DATA_W     = 32,
  parameter int               MIN_BIN    = 2,
  parameter int               MAX_BIN    = 4095,
  parameter logic [MAG_W-1:0] THRESH     = THRESH_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                AUD_ADCLRCK,
  fft_peak_detector_if.slave  src,
  output logic                peak_valid,
  output logic                peak_found,
  output logic [BIN_W-1:0]    peak_bin,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                frame_error,
  output logic                busy
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_POINTS - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst;
  logic             r_ready;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [BIN_W-1:0] w_bin_nxt;
  logic [BIN_W-1:0] w_feed_bin;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_ign;
  logic             w_ign_nxt;

  logic             w_acc;
  logic             w_feed;
  logic             w_start;
  logic             w_flush;
  logic             w_pv_nxt;
  logic             w_fe_nxt;

  logic             w_s1_vld;
  logic             w_s2_vld;
  logic [MAG_W-1:0] w_s2_mag;
  bin_meta_t        w_s2_meta;

  logic [MAG_W-1:0] r_max_mag;
  logic [BIN_W-1:0] r_max_bin;

  logic             r_peak_valid;
  logic             r_peak_found;
  logic [BIN_W-1:0] r_peak_bin;
  logic [MAG_W-1:0] r_peak_mag;
  logic             r_frame_error;

  // Assert asynchronously, release two edges after AUD_ADCLRCK falls.
  always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
    if (AUD_ADCLRCK) r_rst_sync <= 2'b11;
    else             r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end
  assign src.source_ready = r_ready;
  assign w_acc = src.source_valid & r_ready;

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_err   <= 1'b0;
      r_ign   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_err   <= w_err_nxt;
      r_ign   <= w_ign_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_err_nxt   = r_err;
    w_ign_nxt   = r_ign;
    w_feed      = 1'b0;
    w_feed_bin  = r_bin;
    w_start     = 1'b0;
    w_flush     = 1'b0;
    w_pv_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_acc && src.source_sop) begin
          w_start    = 1'b1;
          w_feed     = 1'b1;
          w_feed_bin = '0;
        end
      end
      ST_ACCUM: begin
        if (w_acc && src.source_sop) begin
          // Abort the current frame and restart on this beat.
          w_fe_nxt   = 1'b1;
          w_flush    = 1'b1;
          w_start    = 1'b1;
          w_feed     = 1'b1;
          w_feed_bin = '0;
        end else if (w_acc && !r_ign) begin
          w_feed = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!w_s1_vld && !w_s2_vld) begin
          w_state_nxt = ST_IDLE;
          w_pv_nxt    = ~r_err;
          w_fe_nxt    = r_err;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_feed) begin
      w_err_nxt   = (w_start ? 1'b0 : r_err) | (|src.source_error);
      w_bin_nxt   = w_feed_bin + 1'b1;
      w_ign_nxt   = 1'b0;
      w_state_nxt = ST_ACCUM;
      if (src.source_eop) begin
        w_state_nxt = ST_FLUSH;
        if (w_feed_bin != LAST_BIN) w_err_nxt = 1'b1;
      end else if (w_feed_bin == LAST_BIN) begin
        w_err_nxt = 1'b1;
        w_ign_nxt = 1'b1;
      end
    end
  end

  fft_mag_sq #(
    .MIN_BIN (MIN_BIN),
    .MAX_BIN (MAX_BIN)
  ) u_mag_sq (
    .CLOCK_50 (CLOCK_50),
    .i_rst    (w_rst),
    .i_vld    (w_feed),
    .i_flush  (w_flush),
    .i_re     (src.source_real[DATA_W-1 -: MAG_IN_W]),
    .i_im     (src.source_imag[DATA_W-1 -: MAG_IN_W]),
    .i_bin    (w_feed_bin),
    .o_s1_vld (w_s1_vld),
    .o_vld    (w_s2_vld),
    .o_mag    (w_s2_mag),
    .o_meta   (w_s2_meta)
  );

  // Strict compare keeps the lowest bin on ties.
  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_max_mag <= '0;
      r_max_bin <= '0;
    end else if (w_start) begin
      r_max_mag <= '0;
      r_max_bin <= '0;
    end else if (w_s2_vld && w_s2_meta.in_range && (w_s2_mag > r_max_mag)) begin
      r_max_mag <= w_s2_mag;
      r_max_bin <= w_s2_meta.bin;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_peak_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_peak_found  <= 1'b0;
      r_peak_bin    <= '0;
      r_peak_mag    <= '0;
    end else begin
      r_peak_valid  <= w_pv_nxt;
      r_frame_error <= w_fe_nxt;
      if (w_pv_nxt) begin
        r_peak_found <= (r_max_mag >= THRESH);
        r_peak_bin   <= r_max_bin;
        r_peak_mag   <= r_max_mag;
      end
    end
  end

  assign peak_valid  = r_peak_valid;
  assign frame_error = r_frame_error;
  assign peak_found  = r_peak_found;
  assign peak_bin    = r_peak_bin;
  assign peak_mag    = r_peak_mag;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed and randomized frames against a frame-level peak model; outputs compared every cycle.
module tb_fft_peak_detector;

  localparam int     T     = 20;
  localparam int     NP    = 8192;
  localparam int     MIN_B = 2;
  localparam int     MAX_B = 4095;
  localparam longint THR   = 1000000;

  typedef struct packed {
    logic [63:0] due;
    logic        is_err;
    logic [12:0] bin;
    logic [32:0] mag;
    logic        found;
  } ev_t;

  logic CLOCK_50 = 1'b0;
  logic AUD_ADCLRCK;
  always #(T/2) CLOCK_50 = ~CLOCK_50;

  fft_peak_detector_if #(.DATA_W(32)) src ();

  logic        peak_valid;
  logic        peak_found;
  logic [12:0] peak_bin;
  logic [32:0] peak_mag;
  logic        frame_error;
  logic        busy;

  fft_peak_detector dut (
    .CLOCK_50    (CLOCK_50),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .src         (src),
    .peak_valid  (peak_valid),
    .peak_found  (peak_found),
    .peak_bin    (peak_bin),
    .peak_mag    (peak_mag),
    .frame_error (frame_error),
    .busy        (busy)
  );

  logic [31:0] re_a [NP];
  logic [31:0] im_a [NP];
  int          err_beat;
  bit          in_frame;
  bit          ready_exp;
  ev_t         q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_pv     = 0;
  int n_fe     = 0;

  logic [12:0] m_bin;
  logic [32:0] m_mag;
  logic        m_found;
  logic        e_pv;
  logic        e_fe;
  ev_t         ev_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (AUD_ADCLRCK) begin
      m_bin   = '0;
      m_mag   = '0;
      m_found = 1'b0;
      chk("reset_outputs",
          {src.source_ready, busy, peak_valid, frame_error, peak_found, peak_bin, peak_mag}, 64'd0);
    end else begin
      e_pv = 1'b0;
      e_fe = 1'b0;
      if (q.size() != 0 && q[0].due == $time) begin
        ev_c = q.pop_front();
        if (ev_c.is_err) e_fe = 1'b1;
        else begin
          e_pv    = 1'b1;
          m_bin   = ev_c.bin;
          m_mag   = ev_c.mag;
          m_found = ev_c.found;
        end
      end
      chk("outputs", {peak_valid, frame_error, peak_found, peak_bin, peak_mag},
                     {e_pv, e_fe, m_found, m_bin, m_mag});
      if (ready_exp) chk("ready_high", src.source_ready, 1);
      if (peak_valid) n_pv++;
      if (frame_error) n_fe++;
    end
  end

  task automatic model(output logic [12:0] bin, output logic [32:0] mag);
    longint best, r, i, m;
    logic signed [15:0] rs, is;
    best = 0;
    bin  = '0;
    for (int b = MIN_B; b <= MAX_B; b++) begin
      rs = re_a[b][31:16];
      is = im_a[b][31:16];
      r  = longint'(rs);
      i  = longint'(is);
      m  = r * r + i * i;
      if (m > best) begin
        best = m;
        bin  = 13'(b);
      end
    end
    mag = 33'(best);
  endtask

  task automatic idle(input int n);
    src.source_valid = 1'b0;
    repeat (n) begin
      src.source_sop   = 1'($urandom_range(1));
      src.source_eop   = 1'($urandom_range(1));
      src.source_real  = $urandom();
      src.source_imag  = $urandom();
      src.source_error = 2'($urandom_range(3));
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic beat(input logic [31:0] re, input logic [31:0] im, input bit sop, input bit eop,
                      input logic [1:0] err, output logic [63:0] t);
    src.source_valid = 1'b1;
    src.source_sop   = sop;
    src.source_eop   = eop;
    src.source_real  = re;
    src.source_imag  = im;
    src.source_error = err;
    @(posedge CLOCK_50);
    t = $time;
    #1;
    src.source_valid = 1'b0;
  endtask

  task automatic send(input int nbeats, input bit with_eop, input bit gaps);
    logic [63:0] t;
    ev_t         ev;
    logic [12:0] mb;
    logic [32:0] mm;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(7) == 0) idle($urandom_range(3, 1));
      beat(re_a[b], im_a[b], b == 0, with_eop && (b == nbeats - 1),
           (b == err_beat) ? 2'b01 : 2'b00, t);
      if (b == 0 && in_frame) begin
        ev        = '0;
        ev.due    = t + 64'(T/2);
        ev.is_err = 1'b1;
        q.push_back(ev);
      end
    end
    in_frame = !with_eop;
    if (with_eop) begin
      ev     = '0;
      ev.due = t + 64'(3*T + T/2);
      if (nbeats == NP && err_beat < 0) begin
        model(mb, mm);
        ev.bin   = mb;
        ev.mag   = mm;
        ev.found = (longint'(mm) >= THR);
      end else begin
        ev.is_err = 1'b1;
      end
      q.push_back(ev);
    end
  endtask

  task automatic clear_frame();
    for (int b = 0; b < NP; b++) begin
      re_a[b] = '0;
      im_a[b] = '0;
    end
  endtask

  task automatic rand_frame();
    for (int b = 0; b < NP; b++) begin
      re_a[b] = $urandom();
      im_a[b] = $urandom();
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !src.source_ready; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
    chk("ready_after_reset", src.source_ready, 1);
    ready_exp = 1'b1;
  endtask

  initial begin
    #(T * 120000);
    $display("FAIL timeout: got no finish expected finish within bound");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int pv0, fe0;
    AUD_ADCLRCK      = 1'b1;
    ready_exp        = 1'b0;
    in_frame         = 1'b0;
    err_beat         = -1;
    src.source_valid = 1'b0;
    src.source_sop   = 1'b0;
    src.source_eop   = 1'b0;
    src.source_real  = '0;
    src.source_imag  = '0;
    src.source_error = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_state", {src.source_ready, busy, peak_valid, frame_error, peak_found, peak_bin, peak_mag}, 0);
    AUD_ADCLRCK = 1'b0;
    wait_ready();

    clear_frame();
    re_a[100] = 32'h4000_0000;
    send(NP, 1, 0);
    idle(6);
    chk("tone_bin", peak_bin, 100);
    chk("tone_mag", peak_mag, 33'h1000_0000);
    chk("tone_found", peak_found, 1);
    chk("tone_pulses", {n_pv[15:0], n_fe[15:0]}, {16'd1, 16'd0});

    clear_frame();
    re_a[50] = 32'h2000_0000;
    re_a[60] = 32'h2000_0000;
    send(NP, 1, 0);
    idle(6);
    chk("tie_bin", peak_bin, 50);
    chk("tie_mag", peak_mag, 33'h0400_0000);

    clear_frame();
    re_a[0]   = 32'h7FFF_0000;
    re_a[300] = 32'h1000_0000;
    send(NP, 1, 0);
    idle(6);
    chk("excl_dc_bin", peak_bin, 300);
    chk("excl_dc_mag", peak_mag, 33'h0100_0000);

    clear_frame();
    re_a[5000] = 32'h7000_0000;
    re_a[10]   = 32'h3000_0000;
    send(NP, 1, 0);
    idle(6);
    chk("excl_hi_bin", peak_bin, 10);
    chk("excl_hi_mag", peak_mag, 33'h0900_0000);

    for (int b = 0; b < NP; b++) begin
      re_a[b] = 32'h0001_0000;
      im_a[b] = '0;
    end
    send(NP, 1, 0);
    idle(6);
    chk("weak_bin", peak_bin, MIN_B);
    chk("weak_mag", peak_mag, 1);
    chk("weak_found", peak_found, 0);

    pv0 = n_pv; fe0 = n_fe;
    send(100, 1, 0);
    idle(6);
    chk("short_fe", n_fe - fe0, 1);
    chk("short_no_pv", n_pv - pv0, 0);
    chk("short_held_bin", peak_bin, MIN_B);

    pv0 = n_pv; fe0 = n_fe;
    rand_frame();
    err_beat = 7;
    send(NP, 1, 0);
    err_beat = -1;
    idle(6);
    chk("srcerr_fe", n_fe - fe0, 1);
    chk("srcerr_no_pv", n_pv - pv0, 0);
    chk("srcerr_held_mag", peak_mag, 1);

    pv0 = n_pv; fe0 = n_fe;
    rand_frame();
    send(400, 0, 0);
    rand_frame();
    send(NP, 1, 0);
    idle(6);
    chk("stray_fe", n_fe - fe0, 1);
    chk("stray_pv", n_pv - pv0, 1);

    rand_frame();
    send(4000, 0, 1);
    chk("busy_mid_frame", busy, 1);
    @(posedge CLOCK_50);
    #3;
    AUD_ADCLRCK = 1'b1;
    ready_exp   = 1'b0;
    q.delete();
    in_frame    = 1'b0;
    #1;
    chk("reset_async", {src.source_ready, busy, peak_valid, frame_error, peak_found, peak_bin, peak_mag}, 0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    AUD_ADCLRCK = 1'b0;
    wait_ready();

    pv0 = n_pv; fe0 = n_fe;
    rand_frame();
    send(NP, 1, 1);
    idle(6);
    chk("post_reset_pulses", {n_pv[15:0] - pv0[15:0], n_fe[15:0] - fe0[15:0]}, {16'd1, 16'd0});
    chk("idle_not_busy", busy, 0);

    idle(10);
    chk("events_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
